// File: rtl/sm83_irq_pkg.sv
// Shared constants and types for the sm83 interrupt controller.
// Register addresses, source indices and the IRQ vector type.
package sm83_irq_pkg;

    localparam logic [15:0] IF_ADR = 16'hff0f;
    localparam logic [15:0] IE_ADR = 16'hffff;

    typedef enum logic [2:0] {
        IRQ_VBLANK = 3'd0,
        IRQ_STAT   = 3'd1,
        IRQ_TIMER  = 3'd2,
        IRQ_SERIAL = 3'd3,
        IRQ_JOYPAD = 3'd4
    } irq_src_e;

    typedef logic [7:0] irq_t;

    typedef enum logic [1:0] {
        SelNone = 2'd0,
        SelIf   = 2'd1,
        SelIe   = 2'd2
    } reg_sel_e;

endpackage

// File: rtl/sm83_irq_ctrl_if.sv
// CPU-side bus and IRQ/acknowledge signals of the interrupt controller.
interface sm83_irq_ctrl_if #(
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned ADR_WIDTH = 16,
    parameter int unsigned NUM_IRQS  = 8
);

    logic [ADR_WIDTH-1:0] adr;
    logic [WORD_SIZE-1:0] din;
    logic [WORD_SIZE-1:0] dout;
    logic                 dout_oe;
    logic                 p_rd;
    logic                 p_wr;
    logic [NUM_IRQS-1:0]  irq;
    logic [NUM_IRQS-1:0]  iack;

    modport master (
        output adr,
        output din,
        output p_rd,
        output p_wr,
        output iack,
        input  dout,
        input  dout_oe,
        input  irq
    );

    modport slave (
        input  adr,
        input  din,
        input  p_rd,
        input  p_wr,
        input  iack,
        output dout,
        output dout_oe,
        output irq
    );

endinterface

// File: rtl/sm83_irq_edge.sv
// Registers a level vector and reports the bits that rose since the last clock.
module sm83_irq_edge #(
    parameter int unsigned WIDTH          = 1,
    parameter bit          CLEAR_ON_RESET = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sig_i,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] sig_d;
    logic [WIDTH-1:0] sig_q;

    // Without clear, the history tracks the line through reset so a level
    // already high at release is not mistaken for a new edge.
    always_comb begin
        sig_d = sig_i;
        if (CLEAR_ON_RESET && reset) begin
            sig_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        sig_q <= sig_d;
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/sm83_irq_ctrl.sv
// Interrupt controller: IF/IE registers, source edge latching and iack clearing.
// Drives the CPU irq vector and answers bus reads of 0xFF0F / 0xFFFF.
module sm83_irq_ctrl #(
    parameter int unsigned          WORD_SIZE = 8,
    parameter int unsigned          ADR_WIDTH = 16,
    parameter int unsigned          NUM_IRQS  = 8,
    parameter int unsigned          NUM_SRC   = 5,
    parameter logic [ADR_WIDTH-1:0] IF_ADR    = sm83_irq_pkg::IF_ADR,
    parameter logic [ADR_WIDTH-1:0] IE_ADR    = sm83_irq_pkg::IE_ADR
) (
    input  logic               clk,
    input  logic               reset,
    sm83_irq_ctrl_if.slave     bus,
    input  logic [NUM_SRC-1:0] src
);

    import sm83_irq_pkg::*;

    logic [NUM_SRC-1:0]   src_rise;
    logic [0:0]           p_wr_rise;
    logic                 wr_stb;
    reg_sel_e             sel;

    logic [NUM_SRC-1:0]   if_d;
    logic [NUM_SRC-1:0]   if_q;
    logic [WORD_SIZE-1:0] ie_d;
    logic [WORD_SIZE-1:0] ie_q;

    sm83_irq_edge #(
        .WIDTH          (NUM_SRC),
        .CLEAR_ON_RESET (1'b0)
    ) u_src_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_i  (src),
        .rise_o (src_rise)
    );

    // Write history clears on reset so a strobe held across release writes again.
    sm83_irq_edge #(
        .WIDTH          (1),
        .CLEAR_ON_RESET (1'b1)
    ) u_wr_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_i  (bus.p_wr),
        .rise_o (p_wr_rise)
    );

    assign wr_stb = p_wr_rise[0] & ~reset;

    always_comb begin
        sel = SelNone;
        if (bus.adr == IF_ADR) begin
            sel = SelIf;
        end else if (bus.adr == IE_ADR) begin
            sel = SelIe;
        end
    end

    // Bus write lowest, then iack clear, then a fresh source edge wins.
    always_comb begin
        if_d = if_q;
        ie_d = ie_q;
        if (wr_stb && (sel == SelIf)) begin
            if_d = bus.din[NUM_SRC-1:0];
        end
        if (wr_stb && (sel == SelIe)) begin
            ie_d = bus.din;
        end
        if_d = (if_d & ~bus.iack[NUM_SRC-1:0]) | src_rise;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_q <= '0;
            ie_q <= '0;
        end else begin
            if_q <= if_d;
            ie_q <= ie_d;
        end
    end

    always_comb begin
        bus.dout    = '0;
        bus.dout_oe = 1'b0;
        if (bus.p_rd && !reset) begin
            unique case (sel)
                SelIf: begin
                    bus.dout    = {{(WORD_SIZE - NUM_SRC){1'b1}}, if_q};
                    bus.dout_oe = 1'b1;
                end
                SelIe: begin
                    bus.dout    = ie_q;
                    bus.dout_oe = 1'b1;
                end
                default: begin
                    bus.dout    = '0;
                    bus.dout_oe = 1'b0;
                end
            endcase
        end
    end

    assign bus.irq = {{(NUM_IRQS - NUM_SRC){1'b0}}, if_q & ie_q[NUM_SRC-1:0]};

    // Acknowledges for unimplemented sources have nothing to clear.
    logic unused_iack;
    assign unused_iack = ^bus.iack[NUM_IRQS-1:NUM_SRC];

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// Bench for sm83_irq_ctrl: directed vector table, then random traffic
// compared against a rule-level model of the IF/IE registers.
module tb_sm83_irq_ctrl;

    localparam logic [15:0] A_IF = 16'hff0f;
    localparam logic [15:0] A_IE = 16'hffff;

    typedef struct {
        logic        chk;
        logic        rst;
        logic [15:0] adr;
        logic [7:0]  din;
        logic        rd;
        logic        wr;
        logic [4:0]  src;
        logic [7:0]  iack;
        logic [7:0]  e_irq;
        logic [7:0]  e_dout;
        logic        e_oe;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] src;

    sm83_irq_ctrl_if bus ();

    sm83_irq_ctrl u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .src   (src)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: flag bits, enable byte and the previous input levels.
    logic [4:0] m_if;
    logic [7:0] m_ie;
    logic [4:0] m_src_prev;
    logic       m_wr_prev;

    vec_t tbl[$];

    function automatic vec_t mk(input logic chk, input logic rst, input logic [15:0] adr,
                                input logic [7:0] din, input logic rd, input logic wr,
                                input logic [4:0] s, input logic [7:0] iack,
                                input logic [7:0] e_irq, input logic [7:0] e_dout,
                                input logic e_oe);
        vec_t v;
        v.chk = chk; v.rst = rst; v.adr = adr; v.din = din; v.rd = rd; v.wr = wr;
        v.src = s; v.iack = iack; v.e_irq = e_irq; v.e_dout = e_dout; v.e_oe = e_oe;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step(input vec_t v);
        logic wrote;
        logic b;
        if (v.rst) begin
            m_if      = '0;
            m_ie      = '0;
            m_wr_prev = 1'b0;
        end else begin
            wrote = v.wr && !m_wr_prev;
            for (int i = 0; i < 5; i++) begin
                b = m_if[i];
                if (wrote && v.adr == A_IF) b = v.din[i];
                if (v.iack[i]) b = 1'b0;
                if (v.src[i] && !m_src_prev[i]) b = 1'b1;
                m_if[i] = b;
            end
            if (wrote && v.adr == A_IE) m_ie = v.din;
            m_wr_prev = v.wr;
        end
        m_src_prev = v.src;
    endtask

    task automatic run_cycle(input vec_t v, input bit use_model, input string tag);
        logic [7:0] x_irq;
        logic [7:0] x_dout;
        logic       x_oe;
        reset    = v.rst;
        bus.adr  = v.adr;
        bus.din  = v.din;
        bus.p_rd = v.rd;
        bus.p_wr = v.wr;
        bus.iack = v.iack;
        src      = v.src;
        @(negedge clk);
        if (use_model) begin
            x_irq  = {3'b000, m_if & m_ie[4:0]};
            x_dout = 8'h00;
            x_oe   = 1'b0;
            if (!v.rst && v.rd && v.adr == A_IF) begin
                x_dout = {3'b111, m_if};
                x_oe   = 1'b1;
            end else if (!v.rst && v.rd && v.adr == A_IE) begin
                x_dout = m_ie;
                x_oe   = 1'b1;
            end
        end else begin
            x_irq  = v.e_irq;
            x_dout = v.e_dout;
            x_oe   = v.e_oe;
        end
        if (v.chk) begin
            check({tag, " irq"}, bus.irq, x_irq);
            check({tag, " dout"}, bus.dout, x_dout);
            check({tag, " dout_oe"}, {7'd0, bus.dout_oe}, {7'd0, x_oe});
        end
        @(posedge clk);
        model_step(v);
        #1;
    endtask

    initial begin
        vec_t       v;
        logic [4:0] rs;
        logic       rw;
        int         r;

        reset = 1'b1; src = '0;
        bus.adr = '0; bus.din = '0; bus.p_rd = 1'b0; bus.p_wr = 1'b0; bus.iack = '0;
        m_if = '0; m_ie = '0; m_src_prev = '0; m_wr_prev = 1'b0;

        //              chk rst adr    din    rd wr src    iack   irq    dout   oe
        tbl.push_back(mk(0, 1, 16'h0000, 8'h00, 0, 0, 5'h01, 8'h00, 8'h00, 8'h00, 0));
        tbl.push_back(mk(1, 1, 16'h0000, 8'h00, 0, 0, 5'h01, 8'h00, 8'h00, 8'h00, 0));
        tbl.push_back(mk(1, 0, A_IF,     8'h00, 1, 0, 5'h01, 8'h00, 8'h00, 8'he0, 1));
        tbl.push_back(mk(1, 0, A_IF,     8'h00, 1, 0, 5'h01, 8'h00, 8'h00, 8'he0, 1));
        tbl.push_back(mk(1, 0, A_IE,     8'h04, 0, 1, 5'h00, 8'h00, 8'h00, 8'h00, 0));
        tbl.push_back(mk(1, 0, A_IE,     8'h00, 0, 0, 5'h04, 8'h00, 8'h00, 8'h00, 0));
        tbl.push_back(mk(1, 0, A_IF,     8'h00, 1, 0, 5'h00, 8'h00, 8'h04, 8'he4, 1));
        tbl.push_back(mk(1, 0, A_IF,     8'h00, 1, 0, 5'h00, 8'h04, 8'h04, 8'he4, 1));
        tbl.push_back(mk(1, 0, A_IF,     8'h00, 1, 0, 5'h00, 8'h00, 8'h00, 8'he0, 1));
        tbl.push_back(mk(1, 0, 16'h0000, 8'h00, 0, 0, 5'h04, 8'h00, 8'h00, 8'h00, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 8'h00, 0, 0, 5'h00, 8'h00, 8'h04, 8'h00, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 8'h00, 0, 0, 5'h04, 8'h04, 8'h04, 8'h00, 0));
        tbl.push_back(mk(1, 0, A_IF,     8'h00, 1, 0, 5'h00, 8'h00, 8'h04, 8'he4, 1));
        tbl.push_back(mk(1, 0, 16'h0000, 8'h00, 0, 0, 5'h00, 8'h04, 8'h04, 8'h00, 0));
        tbl.push_back(mk(1, 0, A_IF,     8'h00, 1, 0, 5'h00, 8'h00, 8'h00, 8'he0, 1));
        tbl.push_back(mk(1, 0, A_IE,     8'h00, 0, 1, 5'h00, 8'h00, 8'h00, 8'h00, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 8'h00, 0, 0, 5'h00, 8'h00, 8'h00, 8'h00, 0));
        tbl.push_back(mk(1, 0, A_IF,     8'h1f, 0, 1, 5'h00, 8'h00, 8'h00, 8'h00, 0));
        tbl.push_back(mk(1, 0, A_IF,     8'h1f, 1, 1, 5'h00, 8'h00, 8'h00, 8'hff, 1));
        tbl.push_back(mk(1, 0, A_IF,     8'h1f, 1, 1, 5'h01, 8'h00, 8'h00, 8'hff, 1));
        tbl.push_back(mk(1, 0, A_IF,     8'h1f, 1, 1, 5'h00, 8'h00, 8'h00, 8'hff, 1));
        tbl.push_back(mk(1, 0, A_IF,     8'h00, 1, 0, 5'h00, 8'h00, 8'h00, 8'hff, 1));
        // Held strobe with changing data: only the first value may land.
        tbl.push_back(mk(1, 0, A_IF,     8'h00, 0, 1, 5'h00, 8'h00, 8'h00, 8'h00, 0));
        tbl.push_back(mk(1, 0, A_IF,     8'h1f, 1, 1, 5'h00, 8'h00, 8'h00, 8'he0, 1));
        tbl.push_back(mk(1, 0, A_IF,     8'h1f, 1, 0, 5'h00, 8'h00, 8'h00, 8'he0, 1));
        tbl.push_back(mk(1, 0, A_IF,     8'h1f, 0, 1, 5'h00, 8'h00, 8'h00, 8'h00, 0));
        tbl.push_back(mk(1, 0, A_IF,     8'h00, 1, 0, 5'h00, 8'h00, 8'h00, 8'hff, 1));
        tbl.push_back(mk(1, 0, A_IF,     8'h00, 1, 1, 5'h08, 8'h00, 8'h00, 8'hff, 1));
        tbl.push_back(mk(1, 0, A_IF,     8'h00, 1, 0, 5'h08, 8'h00, 8'h00, 8'he8, 1));
        tbl.push_back(mk(1, 0, A_IE,     8'ha5, 0, 1, 5'h00, 8'h00, 8'h00, 8'h00, 0));
        tbl.push_back(mk(1, 0, A_IE,     8'h00, 1, 0, 5'h00, 8'h00, 8'h00, 8'ha5, 1));
        tbl.push_back(mk(1, 0, 16'hff10, 8'h00, 1, 0, 5'h00, 8'h00, 8'h00, 8'h00, 0));
        tbl.push_back(mk(1, 0, A_IE,     8'h08, 0, 1, 5'h00, 8'h00, 8'h00, 8'h00, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 8'h00, 0, 0, 5'h00, 8'h00, 8'h08, 8'h00, 0));
        // Reset during a write, strobe still high after release.
        tbl.push_back(mk(1, 1, A_IE,     8'hff, 0, 1, 5'h00, 8'h00, 8'h08, 8'h00, 0));
        tbl.push_back(mk(1, 0, A_IE,     8'h3c, 0, 1, 5'h00, 8'h00, 8'h00, 8'h00, 0));
        tbl.push_back(mk(1, 0, A_IE,     8'h00, 1, 0, 5'h00, 8'h00, 8'h00, 8'h3c, 1));
        // Multi-hot iack with upper bits set.
        tbl.push_back(mk(1, 0, A_IF,     8'h1f, 0, 1, 5'h00, 8'h00, 8'h00, 8'h00, 0));
        tbl.push_back(mk(1, 0, A_IF,     8'h00, 1, 0, 5'h00, 8'hea, 8'h1c, 8'hff, 1));
        tbl.push_back(mk(1, 0, A_IF,     8'h00, 1, 0, 5'h00, 8'h00, 8'h14, 8'hf5, 1));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            run_cycle(tbl[i], 1'b0, $sformatf("row%0d", i));
        end

        rs = '0;
        rw = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            v.chk = (n != 0);
            v.rst = (n == 0) || ($urandom_range(0, 63) == 0);
            r = $urandom_range(0, 3);
            case (r)
                0:       v.adr = A_IF;
                1:       v.adr = A_IE;
                2:       v.adr = 16'hff10;
                default: v.adr = 16'($urandom);
            endcase
            v.din = 8'($urandom);
            v.rd  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) rw = ~rw;
            v.wr  = rw;
            rs    = rs ^ 5'($urandom & $urandom);
            v.src = rs;
            r = $urandom_range(0, 9);
            if (r < 5) v.iack = 8'h00;
            else if (r < 9) v.iack = 8'(1 << $urandom_range(0, 7));
            else v.iack = 8'($urandom);
            v.e_irq = 8'h00; v.e_dout = 8'h00; v.e_oe = 1'b0;
            run_cycle(v, 1'b1, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sm83_irq_ctrl.md
# sm83_irq_ctrl

Interrupt controller on the responder side of the sm83 bus and IRQ interface. It holds the interrupt flag register (IF, 0xFF0F) and the interrupt enable register (IE, 0xFFFF), both reachable by CPU reads and writes. It latches rising edges from peripheral request lines and drives the CPU's `irq` vector. It clears flags when the CPU returns one-hot `iack`.

## Interface
Parameters:
- WORD_SIZE, 8, data width
- ADR_WIDTH, 16, address width
- NUM_IRQS, 8, width of irq/iack vectors
- NUM_SRC, 5, implemented sources; bit 0 = vblank, 1 = stat, 2 = timer, 3 = serial, 4 = joypad
- IF_ADR, 16'hff0f, IF register address
- IE_ADR, 16'hffff, IE register address

Ports:
- clk  in  1  system clock. One clock domain; all state updates on posedge clk.
- reset  in  1  synchronous, active-high
- adr  in  ADR_WIDTH  CPU address bus
- din  in  WORD_SIZE  CPU write data
- dout  out  WORD_SIZE  read data; 0 when not selected
- dout_oe  out  1  high when p_rd is high and adr hits IF_ADR or IE_ADR
- p_rd  in  1  CPU read strobe, active-high
- p_wr  in  1  CPU write strobe, active-high; may stay high for several clk
- src  in  NUM_SRC  peripheral request lines, level, synchronous to clk
- irq  out  NUM_IRQS  pending and enabled interrupts to CPU
- iack  in  NUM_IRQS  CPU acknowledge, one-hot or zero, one clk per acknowledge

## Operation
- State: IF[NUM_SRC-1:0], IE[WORD_SIZE-1:0], src_q[NUM_SRC-1:0], p_wr_q.
- Edge: edge = src & ~src_q.
- src_q <= src every clk, including during reset, so a line already high at reset release sets no flag.
- Write strobe: wr_stb = p_wr & ~p_wr_q. Exactly one write per bus write cycle, regardless of strobe length.
- IF next value, per bit: IF_next = ((wr_stb && adr==IF_ADR ? din[NUM_SRC-1:0] : IF) & ~iack[NUM_SRC-1:0]) | edge.
  - Precedence, highest first: edge set > iack clear > bus write.
- IE: IE <= din when wr_stb and adr==IE_ADR. All 8 bits are stored and read back.
- Reads (combinational):
  - IF_ADR → {1 in bits WORD_SIZE-1..NUM_SRC, IF}, i.e. upper 3 bits read 1.
  - IE_ADR → IE.
  - Otherwise dout = 0 and dout_oe = 0.
- irq = {0, IF & IE[NUM_SRC-1:0]}. Bits NUM_IRQS-1..NUM_SRC are always 0.
- iack bits above NUM_SRC are ignored.
- Multi-hot iack: clears all named bits; not a supported CPU behaviour, but defined.
- No priority encoding here; the CPU selects the lowest set bit.

## Timing
- Reset values: IF = 0, IE = 0, p_wr_q = 0, irq = 0, dout = 0, dout_oe = 0.
- Reset mid-write: write is discarded. After release, a p_wr still held high counts as a new rising edge.
- Source edge at cycle n sets IF at edge n+1; irq is high from cycle n+1, provided IE is set.
- Bus write is captured at the clk where wr_stb = 1 and is visible on dout and irq the following cycle.
- A read during the same cycle as an update returns the pre-update value.
- iack at cycle n: irq bit low from n+1, unless that bit's source has an edge at cycle n.
- Source held high produces one set only; it must fall and rise again to re-flag.

## Structure
- Shared package `sm83_irq_pkg`:
  - IF_ADR and IE_ADR constants.
  - Source index enum: IRQ_VBLANK = 0, IRQ_STAT, IRQ_TIMER, IRQ_SERIAL, IRQ_JOYPAD.
  - typedef irq_t.
- Sub-module `sm83_irq_edge` (parameter WIDTH): registers the input and outputs the rise mask. Instantiated once for src and once (WIDTH = 1) for p_wr.
- Flag and enable registers, address decode and read mux live in the top.

## Test plan
- Reset, src = 5'b00001 held through reset release → IF stays 0, irq = 0. Read 0xFF0F → dout = 8'hE0, dout_oe = 1.
- Write IE = 8'h04, pulse src[2] (timer) → irq = 8'h04 next cycle. Read 0xFF0F → 8'hE4.
- Then iack = 8'h04 for one clk → irq = 0 next cycle, IF reads 8'hE0.
- With IF = 5'b00100, iack[2] and a new rising src[2] in the same cycle → IF[2] remains 1 and irq[2] stays high.
- Hold p_wr high 4 clk at 0xFF0F with din = 8'h1F while src[0] pulses on the third clk:
  - Exactly one write at the first clk.
  - IF = 5'h1F afterwards.
  - The later pulse leaves it at 5'h1F.
  - IE = 0 gives irq = 0.
- Write 0xFF0F = 8'h00 in the same cycle as a rising src[3] → IF = 5'b01000. Read 0xFFFF after writing 8'hA5 → dout = 8'hA5. Read 0xFF10 → dout = 0, dout_oe = 0.
